// File: rtl/fir_delay_line.sv
// Shift-register delay line for FIR filters: TAPS signed samples, tap 0 newest, with fill tracking.
// Optional macro FIR_DLINE_OUT_REG_EN adds one output register stage on taps, tap_valid and primed.
module fir_delay_line #(
   parameter int DATA_W = 16,
   parameter int TAPS   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       flush,
   output logic [TAPS*DATA_W-1:0]     taps,
   output logic                       tap_valid,
   output logic [$clog2(TAPS+1)-1:0]  fill_count,
   output logic                       primed
);

   localparam int CNT_W = $clog2(TAPS+1);

   logic [DATA_W-1:0]      line [TAPS];
   logic [CNT_W-1:0]       count;
   logic                   line_valid;
   logic                   line_primed;
   logic [TAPS*DATA_W-1:0] line_flat;
   logic                   shift;

   // flush outranks a sample presented in the same cycle, which is dropped
   assign shift = in_valid && !flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int k = 0; k < TAPS; k++) line[k] <= '0;
         count      <= '0;
         line_valid <= 1'b0;
      end else begin
         line_valid <= shift;
         if (shift) begin
            line[0] <= in_data;
            for (int k = 1; k < TAPS; k++) line[k] <= line[k-1];
            if (count != CNT_W'(TAPS)) count <= count + CNT_W'(1);
         end
      end
   end

   always_comb begin
      line_flat = '0;
      for (int k = 0; k < TAPS; k++) line_flat[k*DATA_W +: DATA_W] = line[k];
   end

   assign line_primed = (count == CNT_W'(TAPS));
   assign fill_count  = count;

`ifdef FIR_DLINE_OUT_REG_EN
   logic [TAPS*DATA_W-1:0] taps_q;
   logic                   tap_valid_q;
   logic                   primed_q;

   // Retimed copy of the line; a flush reaches here one edge after it clears the line
   always_ff @(posedge clk) begin
      if (reset) begin
         taps_q      <= '0;
         tap_valid_q <= 1'b0;
         primed_q    <= 1'b0;
      end else begin
         taps_q      <= line_flat;
         tap_valid_q <= line_valid;
         primed_q    <= line_primed;
      end
   end

   assign taps      = taps_q;
   assign tap_valid = tap_valid_q;
   assign primed    = primed_q;
`else
   assign taps      = line_flat;
   assign tap_valid = line_valid;
   assign primed    = line_primed;
`endif

endmodule

// File: tb/tb_fir_delay_line.sv
// Directed self-checking bench for fir_delay_line (DATA_W=16, TAPS=8).
// Builds with FIR_DLINE_OUT_REG_EN defined run the registered-output sequence instead of the default one.
module tb_fir_delay_line;

   localparam int DATA_W = 16;
   localparam int TAPS   = 8;
   localparam int TW     = TAPS*DATA_W;

   localparam logic [TW-1:0] FILL_1_8 =
      {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
   localparam logic [TW-1:0] FILL_2_9 =
      {16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
   localparam logic [TW-1:0] FILL_SIGN =
      {16'h8000, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic [TW-1:0]     taps;
   logic              tap_valid;
   logic [3:0]        fill_count;
   logic              primed;

   int tests_run;
   int tests_failed;

   fir_delay_line #(.DATA_W(DATA_W), .TAPS(TAPS)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .flush      (flush),
      .taps       (taps),
      .tap_valid  (tap_valid),
      .fill_count (fill_count),
      .primed     (primed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [TW-1:0] observed,
                              input logic [TW-1:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the active edge
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic f);
      in_valid = v;
      in_data  = d;
      flush    = f;
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_taps"}, taps, '0);
      checkOutput({tag, "_tap_valid"}, TW'(tap_valid), '0);
      checkOutput({tag, "_fill_count"}, TW'(fill_count), '0);
      checkOutput({tag, "_primed"}, TW'(primed), '0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      flush    = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      reset = 1'b0;
      checkAllZero("reset");

`ifdef FIR_DLINE_OUT_REG_EN
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, (i == 1) ? 16'h8000 : DATA_W'(i), 1'b0);
         checkOutput($sformatf("reg_fill_count_%0d", i), TW'(fill_count), TW'(i));
         checkOutput($sformatf("reg_tap_valid_%0d", i), TW'(tap_valid), TW'(i >= 2));
         checkOutput($sformatf("reg_primed_%0d", i), TW'(primed), '0);
      end
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("reg_last_pulse", TW'(tap_valid), TW'(1));
      checkOutput("reg_primed", TW'(primed), TW'(1));
      checkOutput("reg_taps", taps, FILL_SIGN);
      checkOutput("reg_tap7_sign", TW'(taps[7*DATA_W +: DATA_W]), TW'(16'h8000));
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("reg_pulse_end", TW'(tap_valid), '0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("reg_flush_count", TW'(fill_count), '0);
      checkOutput("reg_flush_taps_lag", taps, FILL_SIGN);
      applyStimulus(1'b0, '0, 1'b0);
      checkAllZero("reg_flush");
`else
      // Back-to-back fill with samples 1..8
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, DATA_W'(i), 1'b0);
         checkOutput($sformatf("b2b_tap_valid_%0d", i), TW'(tap_valid), TW'(1));
         checkOutput($sformatf("b2b_fill_count_%0d", i), TW'(fill_count), TW'(i));
         checkOutput($sformatf("b2b_tap0_%0d", i), TW'(taps[DATA_W-1:0]), TW'(i));
         checkOutput($sformatf("b2b_primed_%0d", i), TW'(primed), TW'(i == 8));
      end
      checkOutput("b2b_taps", taps, FILL_1_8);
      applyStimulus(1'b0, 16'h1234, 1'b0);
      checkOutput("idle_tap_valid", TW'(tap_valid), '0);
      checkOutput("idle_taps_hold", taps, FILL_1_8);

      // Saturation: a ninth sample
      applyStimulus(1'b1, 16'd9, 1'b0);
      checkOutput("sat_taps", taps, FILL_2_9);
      checkOutput("sat_fill_count", TW'(fill_count), TW'(8));
      checkOutput("sat_primed", TW'(primed), TW'(1));

      // Flush beats a simultaneous sample
      applyStimulus(1'b1, 16'h7FFF, 1'b1);
      checkAllZero("flush");
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("flush_after_taps", taps, '0);

      // Spaced fill with two idle cycles between samples
      doReset();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, DATA_W'(i), 1'b0);
         checkOutput($sformatf("gap_tap_valid_%0d", i), TW'(tap_valid), TW'(1));
         for (int g = 0; g < 2; g++) begin
            applyStimulus(1'b0, 16'hBEEF, 1'b0);
            checkOutput($sformatf("gap_idle_valid_%0d_%0d", i, g), TW'(tap_valid), '0);
            checkOutput($sformatf("gap_idle_tap0_%0d_%0d", i, g),
                        TW'(taps[DATA_W-1:0]), TW'(i));
            checkOutput($sformatf("gap_idle_count_%0d_%0d", i, g), TW'(fill_count), TW'(i));
         end
      end
      checkOutput("gap_taps", taps, FILL_1_8);
      checkOutput("gap_primed", TW'(primed), TW'(1));

      // Reset mid-fill, also outranking flush and in_valid
      doReset();
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0);
      checkOutput("mid_fill_count", TW'(fill_count), TW'(5));
      reset = 1'b1;
      applyStimulus(1'b1, 16'h0055, 1'b1);
      reset = 1'b0;
      checkAllZero("mid_reset");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, DATA_W'(i), 1'b0);
         checkOutput($sformatf("refill_count_%0d", i), TW'(fill_count), TW'(i));
      end
      checkOutput("refill_taps", taps, FILL_1_8);
      checkOutput("refill_primed", TW'(primed), TW'(1));
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fir_delay_line.md
FIR_DELAY_LINE -- requirements
Module: fir_delay_line

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, sample width in bits (legal 2..32).
REQ-002 The block SHALL have parameter TAPS, default 8, delay-line depth in samples (legal 2..64).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  sample strobe; in_data is accepted on any rising clk edge where in_valid=1.
REQ-006 The block SHALL have port in_data  input  DATA_W  signed sample.
REQ-007 The block SHALL have port flush  input  1  synchronous clear of all taps and of the fill count.
REQ-008 The block SHALL have port taps  output  TAPS*DATA_W  tap k on bits [k*DATA_W +: DATA_W]; tap 0 is the newest sample.
REQ-009 The block SHALL have port tap_valid  output  1  one-cycle pulse marking that taps has just changed because of a shift.
REQ-010 The block SHALL have port fill_count  output  clog2(TAPS+1)  number of valid samples held, saturating at TAPS.
REQ-011 The block SHALL have port primed  output  1  high when fill_count==TAPS.

Function
REQ-012 A shift SHALL occur on each edge where in_valid=1 and flush=0: tap0<=in_data and tap[k]<=tap[k-1] for k=1..TAPS-1; the oldest sample is discarded.
REQ-013 With no shift, all taps SHALL hold their value; in_valid=0 SHALL never change taps.
REQ-014 Base latency SHALL be 1 cycle: a sample accepted at edge N appears on tap 0 after edge N, and tap_valid=1 for exactly the cycle following edge N.
REQ-015 A sample accepted at edge N SHALL reach tap k after the k-th subsequent shift, regardless of the idle cycles between shifts.
REQ-016 fill_count SHALL increment by 1 on each shift while below TAPS, and SHALL then hold at TAPS without wrapping.
REQ-017 primed SHALL be derived from the registered fill_count and SHALL assert in the same cycle as the tap_valid pulse of the TAPS-th shift.
REQ-018 flush=1 SHALL zero all taps and fill_count, deassert primed, and force tap_valid=0 on the next cycle.
REQ-019 flush SHALL take priority over in_valid; a sample presented in the same cycle SHALL be dropped.
REQ-020 Back-to-back in_valid SHALL sustain one shift per cycle with tap_valid held high continuously.
REQ-021 Taps SHALL be passed through unmodified: no arithmetic, rounding or sign handling.

Reset
REQ-022 reset=1 SHALL, at the next rising clk edge, set all taps=0, fill_count=0, primed=0 and tap_valid=0.
REQ-023 reset SHALL take priority over flush and in_valid.
REQ-024 reset asserted mid-fill or mid-stream SHALL discard all held samples; refill SHALL restart from fill_count=0.

Configuration
REQ-025 Macro FIR_DLINE_OUT_REG_EN, when defined, SHALL add one output register stage to taps, tap_valid and primed. Total latency SHALL then be 2 cycles. The stage SHALL be cleared by reset. flush SHALL clear it on the edge after it clears the line.
REQ-026 When FIR_DLINE_OUT_REG_EN is undefined, outputs SHALL be driven directly from the line registers with 1-cycle latency.
REQ-027 fill_count SHALL not be delayed in either build.

Verification (DATA_W=16, TAPS=8, macro undefined unless stated)
REQ-028 Reset, then in_valid for 8 consecutive cycles with samples 1..8:
  - tap_valid is high for 8 cycles.
  - fill_count steps 1..8.
  - primed rises with the 8th pulse.
  - Final taps = {8,7,6,5,4,3,2,1} (tap0=8).
REQ-029 Same 8 samples with 2 idle cycles between each: identical final taps; tap_valid pulses are isolated; taps hold during idle cycles.
REQ-030 Fill with 1..8, then apply 9: tap0=9, tap7=2, fill_count stays 8, primed stays 1.
REQ-031 After priming, flush=1 and in_valid=1 with sample 0x7FFF in the same cycle: taps=0, fill_count=0, primed=0, tap_valid=0; 0x7FFF never appears.
REQ-032 reset asserted after 5 of 8 samples: all outputs are 0 on the next cycle; a subsequent 8-sample fill reproduces REQ-028 exactly.
REQ-033 With FIR_DLINE_OUT_REG_EN defined, rerun REQ-028 with 0x8000 as the first sample:
  - Each tap_valid pulse arrives one cycle later.
  - fill_count timing is unchanged.
  - tap7=0x8000, showing sign bits are preserved.
